board_write_engine: RTL
=======================

// Module: board_write_engine
// PURPOSE
//  Command-driven board-memory sequencer; parametrised successor of the board init/move datapath.
//  Drives the square memory (address, write data, write and read strobes) for three commands.
//  Commands: STANDARD init, CLEAR, and MOVE with capture readback.
//  Sits between the game-control FSM and the board RAM that feeds the VGA renderer.
//  Commands use a valid/ready handshake and finish with a one-cycle done pulse.
// PARAMETERS
//  COORD_W     3  coordinate width; board side N = 2**COORD_W (COORD_W >= 2)
//  PIECE_W     4  piece code width (>= 4)
//  WRITE_WAIT  1  hold cycles after each write strobe (>= 1), address/data stable throughout
//  READ_LAT    1  cycles from mem_re to valid mem_rdata (>= 1)
// PORTS
//  clk             in   1        system clock, rising edge
//  reset           in   1        asynchronous, active-high
//  cmd_valid       in   1        command request
//  cmd_ready       out  1        engine idle; command accepted when cmd_valid & cmd_ready
//  cmd_op          in   2        0 NOP, 1 INIT_STANDARD, 2 CLEAR, 3 MOVE
//  origin_x/_y     in   COORD_W  MOVE source square
//  dest_x/_y       in   COORD_W  MOVE destination square
//  piece_to_move   in   PIECE_W  code written to destination on MOVE
//  mem_x/mem_y     out  COORD_W  memory square address
//  mem_wdata       out  PIECE_W  write data
//  mem_we          out  1        write strobe, exactly 1 cycle per write
//  mem_re          out  1        read strobe, 1 cycle
//  mem_rdata       in   PIECE_W  read data, valid READ_LAT cycles after mem_re
//  done            out  1        1-cycle pulse at end of every accepted non-NOP command
//  err             out  1        valid with done; 1 = MOVE rejected
//  captured_piece  out  PIECE_W  destination contents before the last MOVE; held until next MOVE
// BEHAVIOUR
//  Reset (async): state IDLE; mem_x/mem_y/mem_wdata/captured_piece = 0; mem_we/mem_re/done/err = 0.
//  Reset with cmd_ready = 1. Reset mid-command aborts the command at once (mem_we drops
//  asynchronously), and no done pulse follows.
//  cmd_ready = (state == IDLE), registered. Inputs are sampled only on the accept cycle and
//  latched internally. cmd_valid while busy is ignored, not queued.
//  An accepted NOP stays in IDLE and produces no done.
//  States: IDLE, SCAN_WR, SCAN_WAIT, MV_RD, MV_RD_WAIT, MV_WR_DST, MV_DST_WAIT,
//  MV_WR_ORG, MV_ORG_WAIT, DONE.
//  SCAN (INIT_STANDARD, CLEAR):
//  - Visits all N*N squares, x fastest: (0,0),(1,0)..(N-1,0),(0,1)..(N-1,N-1).
//  - Per square: SCAN_WR (mem_we = 1) for 1 cycle, then SCAN_WAIT for WRITE_WAIT cycles.
//  - In the last wait cycle the engine advances x; when x wraps from N-1 to 0 it advances y.
//  - After square (N-1,N-1): DONE. Total N*N*(1+WRITE_WAIT) cycles, then the DONE cycle.
//  - CLEAR writes 0 to every square.
//  - INIT_STANDARD table, with k = x mod 8 and back[k] = {4,2,3,6,5,3,2,4}:
//    y=0 back[k]; y=1 writes 1; y=N-2 writes 7; y=N-1 back[k]+6; all other rows 0.
//  MOVE:
//  - If origin == dest: go straight to DONE with err = 1. No memory access; captured_piece unchanged.
//  - Otherwise: MV_RD, 1 cycle, mem_re = 1 at dest.
//  - MV_RD_WAIT, READ_LAT cycles; mem_rdata is loaded into captured_piece in its last cycle.
//  - MV_WR_DST: mem_we = 1, writes piece_to_move at dest; then MV_DST_WAIT for WRITE_WAIT cycles.
//  - MV_WR_ORG: mem_we = 1, writes 0 at origin; then MV_ORG_WAIT for WRITE_WAIT cycles.
//  - Then DONE with err = 0.
//  - Default-parameter cycle count: accept at c0, done at c7, cmd_ready again at c8.
//  DONE: lasts 1 cycle with done = 1, then IDLE. err is 0 except on a rejected MOVE.
//  Outside write cycles mem_we = 0; outside MV_RD mem_re = 0.
//  mem_x/mem_y/mem_wdata hold their last values while IDLE.
//  Coordinate arithmetic is modulo N (COORD_W bits); no out-of-range squares exist.
// TESTING
//  1 Async reset mid-INIT (square 20) -> mem_we=0 in the same cycle; cmd_ready=1 after release;
//    no done pulse.
//  2 INIT_STANDARD at defaults -> 64 write strobes spaced 2 cycles apart; done 129 cycles after
//    accept; model memory has (0,0)=4, (3,0)=6, (4,0)=5, (2,1)=1, (5,4)=0, (1,6)=7, (3,7)=12, (7,7)=10.
//  3 MOVE o=(4,6) d=(4,4) piece=7 after INIT -> captured_piece=0; memory (4,4)=7 and (4,6)=0;
//    err=0; done at c7.
//  4 MOVE o=(0,0) d=(0,6) piece=4 with (0,6)=7 -> captured_piece=7; (0,6)=4 and (0,0)=0.
//  5 MOVE o=d=(2,2) -> done with err=1 at c1; no mem_we/mem_re; captured_piece unchanged.
//  6 cmd_valid held high during CLEAR, plus parameter sweep (COORD_W=4, WRITE_WAIT=3, READ_LAT=2)
//    -> second command is ignored until cmd_ready; 256 writes of 0; write strobes spaced 4 cycles.

Source files
------------

// File: rtl/board_write_engine.sv
// board_write_engine: command-driven sequencer that initialises, clears and updates the board memory
module board_write_engine #(
  parameter int COORD_W    = 3,
  parameter int PIECE_W    = 4,
  parameter int WRITE_WAIT = 1,
  parameter int READ_LAT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  input  logic [COORD_W-1:0] dest_x,
  input  logic [COORD_W-1:0] dest_y,
  input  logic [PIECE_W-1:0] piece_to_move,
  output logic [COORD_W-1:0] mem_x,
  output logic [COORD_W-1:0] mem_y,
  output logic [PIECE_W-1:0] mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [PIECE_W-1:0] mem_rdata,
  output logic               done,
  output logic               err,
  output logic [PIECE_W-1:0] captured_piece
);
  localparam int CNT_W = $clog2((WRITE_WAIT > READ_LAT ? WRITE_WAIT : READ_LAT) + 1);
  localparam logic [CNT_W-1:0] WW_LAST = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] RL_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [COORD_W-1:0] TOP = COORD_W'((2 ** COORD_W) - 1);
  localparam logic [COORD_W-1:0] PAWN_ROW = COORD_W'((2 ** COORD_W) - 2);

  typedef enum logic [3:0] {
    IDLE, SCAN_WR, SCAN_WAIT, MV_RD, MV_RD_WAIT, MV_WR_DST, MV_DST_WAIT, MV_WR_ORG, MV_ORG_WAIT, DONE
  } state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;
  logic clr;
  logic [COORD_W-1:0] ox, oy, nx, ny;
  logic [PIECE_W-1:0] pc;
  logic last_sq;

  // Standard opening layout: back rank pattern repeats every 8 files, white pieces offset by 6
  function automatic logic [PIECE_W-1:0] std_piece(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    logic [2:0] k;
    logic [PIECE_W-1:0] b;
    k = 3'(x);
    b = (k == 3'd0 || k == 3'd7) ? PIECE_W'(4) : (k == 3'd1 || k == 3'd6) ? PIECE_W'(2) :
        (k == 3'd2 || k == 3'd5) ? PIECE_W'(3) : (k == 3'd3) ? PIECE_W'(6) : PIECE_W'(5);
    return y == '0 ? b : y == COORD_W'(1) ? PIECE_W'(1) : y == PAWN_ROW ? PIECE_W'(7) :
           y == TOP ? b + PIECE_W'(6) : '0;
  endfunction

  assign nx = mem_x + 1'b1;
  assign ny = mem_x == TOP ? mem_y + 1'b1 : mem_y;
  assign last_sq = mem_x == TOP && mem_y == TOP;

  // Command FSM; every memory strobe and status output is registered alongside the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      mem_x <= '0;
      mem_y <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      captured_piece <= '0;
      cnt <= '0;
      clr <= 1'b0;
      ox <= '0;
      oy <= '0;
      pc <= '0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (cmd_valid && cmd_op != 2'd0) begin
          cmd_ready <= 1'b0;
          clr <= cmd_op == 2'd2;
          ox <= origin_x;
          oy <= origin_y;
          pc <= piece_to_move;
          if (cmd_op != 2'd3) begin
            state <= SCAN_WR;
            mem_x <= '0;
            mem_y <= '0;
            mem_wdata <= cmd_op == 2'd2 ? '0 : std_piece('0, '0);
            mem_we <= 1'b1;
          end else if (origin_x == dest_x && origin_y == dest_y) begin
            state <= DONE;
            done <= 1'b1;
            err <= 1'b1;
          end else begin
            state <= MV_RD;
            mem_x <= dest_x;
            mem_y <= dest_y;
            mem_re <= 1'b1;
          end
        end
        SCAN_WR: begin
          state <= SCAN_WAIT;
          cnt <= '0;
        end
        SCAN_WAIT: if (cnt != WW_LAST) cnt <= cnt + 1'b1;
          else if (last_sq) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            state <= SCAN_WR;
            mem_we <= 1'b1;
            mem_x <= nx;
            mem_y <= ny;
            mem_wdata <= clr ? '0 : std_piece(nx, ny);
          end
        MV_RD: begin
          state <= MV_RD_WAIT;
          cnt <= '0;
        end
        MV_RD_WAIT: if (cnt != RL_LAST) cnt <= cnt + 1'b1;
          else begin
            captured_piece <= mem_rdata;
            state <= MV_WR_DST;
            mem_we <= 1'b1;
            mem_wdata <= pc;
          end
        MV_WR_DST: begin
          state <= MV_DST_WAIT;
          cnt <= '0;
        end
        MV_DST_WAIT: if (cnt != WW_LAST) cnt <= cnt + 1'b1;
          else begin
            state <= MV_WR_ORG;
            mem_we <= 1'b1;
            mem_x <= ox;
            mem_y <= oy;
            mem_wdata <= '0;
          end
        MV_WR_ORG: begin
          state <= MV_ORG_WAIT;
          cnt <= '0;
        end
        MV_ORG_WAIT: if (cnt != WW_LAST) cnt <= cnt + 1'b1;
          else begin
            state <= DONE;
            done <= 1'b1;
          end
        DONE: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
